fiber_dram_responder: RTL



---
 rtl/fiber_pkg.sv | 27 ++
 rtl/fiber_dram_mem.sv | 52 +++++
 rtl/fiber_dram_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fiber_pkg.sv
// Shared definitions for the fiberBank DRAM responder: FSM state encoding,
// default fill pattern and the bank request encodings reused by benches.
package fiber_pkg;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_WB   = 2'd1,
        FSM_WAIT = 2'd2,
        FSM_SEND = 2'd3
    } fsm_state_e;

    // Plain-vector aliases of the enum so the FSM can live in a logic register.
    localparam logic [1:0] ST_IDLE = FSM_IDLE;
    localparam logic [1:0] ST_WB   = FSM_WB;
    localparam logic [1:0] ST_WAIT = FSM_WAIT;
    localparam logic [1:0] ST_SEND = FSM_SEND;

    localparam int unsigned DEFAULT_FILL_PATTERN = 0;

    typedef enum logic [1:0] {
        REQ_FETCH   = 2'd0,
        REQ_READ    = 2'd1,
        REQ_WRITE   = 2'd2,
        REQ_CONSUME = 2'd3
    } req_e;

endpackage

// File: rtl/fiber_dram_mem.sv
// Backing store: unreset data array with synchronous write and registered read,
// plus a per-entry written bitmap that is cleared asynchronously.
module fiber_dram_mem #(
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           MEM_DEPTH    = 1024,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = '0,
    parameter int unsigned           IDX_W        = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_rd_clr,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  written_q, written_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        written_d = written_q;
        if (i_we) written_d[i_wr_idx] = 1'b1;
    end

    // Read register holds its value until the next load so the fill word stays stable.
    always_comb begin
        rd_data_d = rd_data_q;
        if (i_rd_clr) rd_data_d = '0;
        if (i_rd_en)  rd_data_d = written_q[i_rd_idx] ? mem_q[i_rd_idx] : FILL_PATTERN;
    end

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_wr_idx] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            written_q <= '0;
            rd_data_q <= '0;
        end else begin
            written_q <= written_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/fiber_dram_responder.sv
// Memory-side DRAM model for a fiberBank: fixed-latency fills, writebacks into
// a small store. Optional counters are enabled with `define FIBER_DRAM_STATS_EN.
module fiber_dram_responder
    import fiber_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           ADDR_WIDTH   = 64,
    parameter int unsigned           MEM_DEPTH    = 1024,
    parameter int unsigned           READ_LATENCY = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = DATA_WIDTH'(DEFAULT_FILL_PATTERN)
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    input  logic [ADDR_WIDTH-1:0] i_dram_addr,
    input  logic                  i_fill_ready,
    output logic [DATA_WIDTH-1:0] o_fill_data,
    output logic                  o_fill_valid,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_wb_valid,
    output logic                  o_wb_ready,
`ifdef FIBER_DRAM_STATS_EN
    output logic [31:0]           o_fill_count,
    output logic [31:0]           o_wb_count,
`endif
    output logic [1:0]            o_dbg_state
);

    // Handshakes: a writeback transfers on i_wb_valid & o_wb_ready; a fill word
    // transfers on o_fill_valid & i_fill_ready, and once raised valid stays high
    // with stable data until that transfer happens.

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  wb_ready_q, wb_ready_d;
    logic                  fill_valid_q, fill_valid_d;
    logic                  mem_we, mem_rd_en, mem_rd_clr;
    logic [IDX_W-1:0]      addr_idx;
    logic                  unused_addr_hi;

    assign addr_idx       = i_dram_addr[IDX_W-1:0];
    assign unused_addr_hi = ^i_dram_addr[ADDR_WIDTH-1:IDX_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wb_data_d  = wb_data_q;
        mem_we     = 1'b0;
        mem_rd_en  = 1'b0;
        mem_rd_clr = 1'b0;
        case (state_q)
            // wb_ready_q gates acceptance so nothing is taken in the cycle right after reset.
            ST_IDLE: begin
                if (wb_ready_q) begin
                    if (i_wb_valid) begin
                        state_d   = ST_WB;
                        idx_d     = addr_idx;
                        wb_data_d = i_wb_data;
                    end else if (i_fill_ready) begin
                        state_d = ST_WAIT;
                        idx_d   = addr_idx;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            ST_WB: begin
                mem_we  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_SEND;
                    mem_rd_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SEND: begin
                if (i_fill_ready) begin
                    state_d    = ST_IDLE;
                    mem_rd_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wb_ready_d   = (state_d == ST_IDLE);
        fill_valid_d = (state_d == ST_SEND);
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wb_data_q    <= '0;
            wb_ready_q   <= 1'b0;
            fill_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wb_data_q    <= wb_data_d;
            wb_ready_q   <= wb_ready_d;
            fill_valid_q <= fill_valid_d;
        end
    end

    fiber_dram_mem #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEM_DEPTH    (MEM_DEPTH),
        .FILL_PATTERN (FILL_PATTERN),
        .IDX_W        (IDX_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_nreset  (i_nreset),
        .i_we      (mem_we),
        .i_wr_idx  (idx_q),
        .i_wr_data (wb_data_q),
        .i_rd_en   (mem_rd_en),
        .i_rd_clr  (mem_rd_clr),
        .i_rd_idx  (idx_q),
        .o_rd_data (o_fill_data)
    );

`ifdef FIBER_DRAM_STATS_EN
    logic [31:0] fill_count_q, fill_count_d;
    logic [31:0] wb_count_q, wb_count_d;

    always_comb begin
        fill_count_d = fill_count_q;
        wb_count_d   = wb_count_q;
        if (state_q == ST_SEND && i_fill_ready)               fill_count_d = fill_count_q + 32'd1;
        if (state_q == ST_IDLE && wb_ready_q && i_wb_valid)   wb_count_d   = wb_count_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            fill_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            fill_count_q <= fill_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign o_fill_count = fill_count_q;
    assign o_wb_count   = wb_count_q;
`endif

    assign o_fill_valid = fill_valid_q;
    assign o_wb_ready   = wb_ready_q;
    assign o_dbg_state  = state_q;

endmodule
